riscv_dmem_arbiter: RTL
=======================

RISCV_DMEM_ARBITER -- requirements
Module: riscv_dmem_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data/address width.
REQ-002 Parameter: STARVE_LIMIT, 8, consecutive ext wait cycles before forced ext grant (range 1..255).
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  pipeline MEM-stage access request (MemRead|MemWrite).
REQ-006 cpu_we  input  1  1 = store, 0 = load.
REQ-007 cpu_addr  input  XLEN  byte address (dAddress).
REQ-008 cpu_wdata  input  XLEN  store data (dWriteData).
REQ-009 cpu_rdata  output  XLEN  load data, valid cycle after grant (dReadData).
REQ-010 cpu_stall  output  1  CPU request pending but not granted this cycle.
REQ-011 ext_valid  input  1  debug/loader request valid.
REQ-012 ext_ready  output  1  ext request granted this cycle.
REQ-013 ext_we, ext_addr, ext_wdata  input  1/XLEN/XLEN  ext write enable, address, write data.
REQ-014 ext_rdata  output  XLEN  ext load data.
REQ-015 ext_rvalid  output  1  ext_rdata valid, one-cycle pulse.
REQ-016 mem_en, mem_we, mem_addr, mem_wdata  output  1/1/XLEN/XLEN  single-port synchronous data memory port.
REQ-017 mem_rdata  input  XLEN  memory read data, valid cycle after mem_en && !mem_we.

Function
REQ-018 One memory access per cycle; grant decided combinationally from current requests and registered state; mem_* driven from the granted requester in the same cycle.
REQ-019 Default priority: cpu_req beats ext_valid; with no request mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
REQ-020 cpu_stall = cpu_req && !cpu_grant; ext_ready = ext_grant.
REQ-021 Ext handshake completes on ext_valid && ext_ready; ext master holds ext_* stable until then (bench checks, RTL does not).
REQ-022 Read-owner FSM, states RD_NONE, RD_CPU, RD_EXT: next state RD_CPU on a granted CPU load, RD_EXT on a granted ext load, else RD_NONE; every state reachable from every state in one cycle.
REQ-023 In RD_CPU: cpu_rdata = mem_rdata; in RD_EXT: ext_rdata = mem_rdata, ext_rvalid = 1; otherwise ext_rvalid = 0 and rdata outputs hold mem_rdata (don't-care).
REQ-024 Read latency 1 cycle for both requesters; stores complete in the grant cycle, no response.
REQ-025 Back-to-back grants to alternating requesters are legal; no idle bubble between them.

Reset
REQ-026 On rst: FSM = RD_NONE, starvation counter = 0, ext_rvalid = 0; combinational outputs follow REQ-019/020 with registered state at reset values.
REQ-027 Reset asserted while a load is outstanding: the pending ext_rvalid pulse is suppressed.

Configuration
REQ-028 Macro DMEM_ARB_STARVE_GUARD_EN defined: 8-bit counter increments each cycle ext_valid && !ext_ready, saturates at STARVE_LIMIT, clears on ext grant; while counter == STARVE_LIMIT, ext wins over cpu_req and cpu_stall asserts.
REQ-029 Macro undefined: counter absent, strict CPU priority, ext may starve indefinitely.

Structure
REQ-030 Read-owner state enum (RD_NONE/RD_CPU/RD_EXT) and default STARVE_LIMIT constant live in riscv_core_p.
REQ-031 Single flat module; no sub-modules.

Verification
REQ-032 CPU load 0x00002000 alone, mem returns 0xDEADBEEF -> mem_en=1 same cycle, cpu_rdata=0xDEADBEEF next cycle, cpu_stall=0 throughout.
REQ-033 ext store 0x10/0x55 while cpu_req=0 -> ext_ready=1 same cycle, mem_we=1, mem_addr=0x10, no ext_rvalid.
REQ-034 cpu_req and ext_valid both high, guard undefined, 20 cycles -> ext_ready=0 all 20, cpu_stall=0.
REQ-035 Same, guard defined, STARVE_LIMIT=8 -> ext granted in cycle 9, cpu_stall=1 that cycle only, counter back to 0.
REQ-036 Ext load granted, rst asserted next cycle -> ext_rvalid stays 0, FSM RD_NONE.
REQ-037 CPU load then ext load in consecutive cycles -> cpu_rdata valid cycle 2, ext_rvalid=1 with correct data cycle 3.

Source files
------------

// File: rtl/riscv_core_p.sv
// Shared core types: data-memory read-owner encoding and arbiter defaults.
package riscv_core_p;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_EXT  = 2'd2
    } rd_owner_t;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 8;
    localparam int unsigned STARVE_CNT_W         = 8;

endpackage

// File: rtl/riscv_dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and an external debug/loader master.
// Define DMEM_ARB_STARVE_GUARD_EN to add the ext starvation counter; otherwise CPU has strict priority.
module riscv_dmem_arbiter
    import riscv_core_p::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [XLEN-1:0] cpu_addr,
    input  logic [XLEN-1:0] cpu_wdata,
    output logic [XLEN-1:0] cpu_rdata,
    output logic            cpu_stall,

    input  logic            ext_valid,
    output logic            ext_ready,
    input  logic            ext_we,
    input  logic [XLEN-1:0] ext_addr,
    input  logic [XLEN-1:0] ext_wdata,
    output logic [XLEN-1:0] ext_rdata,
    output logic            ext_rvalid,

    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be in 1..255");
    end

    rd_owner_t r_rd_state;
    rd_owner_t w_rd_state_next;

    logic w_cpu_grant;
    logic w_ext_grant;
    logic w_force_ext;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [STARVE_CNT_W-1:0] LimitCnt = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] r_starve_cnt;

    // Gated by rst so grants during reset see the counter at its reset value.
    assign w_force_ext = ext_valid && !rst && (r_starve_cnt == LimitCnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_ext_grant) begin
            r_starve_cnt <= '0;
        end else if (ext_valid && (r_starve_cnt != LimitCnt)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_force_ext = 1'b0;
`endif

    assign w_ext_grant = ext_valid && (!cpu_req || w_force_ext);
    assign w_cpu_grant = cpu_req && !w_ext_grant;

    assign cpu_stall = cpu_req && !w_cpu_grant;
    assign ext_ready = w_ext_grant;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_grant) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_ext_grant) begin
            mem_en    = 1'b1;
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    // Read-owner FSM: remembers who issued last cycle's load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= RD_NONE;
        end else begin
            r_rd_state <= w_rd_state_next;
        end
    end

    always_comb begin
        w_rd_state_next = RD_NONE;
        if (w_cpu_grant && !cpu_we) begin
            w_rd_state_next = RD_CPU;
        end else if (w_ext_grant && !ext_we) begin
            w_rd_state_next = RD_EXT;
        end
    end

    // rdata is a straight wire; only the ext valid pulse depends on ownership.
    always_comb begin
        cpu_rdata  = mem_rdata;
        ext_rdata  = mem_rdata;
        ext_rvalid = 1'b0;
        unique case (r_rd_state)
            RD_EXT:  ext_rvalid = !rst;
            RD_CPU:  ext_rvalid = 1'b0;
            default: ext_rvalid = 1'b0;
        endcase
    end

endmodule
